// File: rtl/msx_bus_pkg.sv
// Shared types and constants for the MSX cartridge-bus transaction block.
package msx_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_RSP = 3'd2,
        DRIVE    = 3'd3,
        DONE     = 3'd4
    } state_t;

    typedef enum logic {
        KIND_MEM = 1'b0,
        KIND_IO  = 1'b1
    } kind_t;

    localparam logic [7:0] BUS_DOUT_IDLE = 8'hFF;

    // Memory cycle aimed at this slot; refresh cycles also assert MERQ and must be excluded.
    function automatic logic mem_qualified(input logic sltsl_n, input logic merq_n,
                                           input logic rfsh_n);
        return (!sltsl_n) && (!merq_n) && rfsh_n;
    endfunction

    function automatic logic io_qualified(input logic iorq_n, input logic m1_n);
        return (!iorq_n) && m1_n;
    endfunction

endpackage

// File: rtl/msx_bus_strobe_edge.sv
// Samples the host read/write strobes and reports falling edges and the released state.
module msx_bus_strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic rd_n,
    input  logic wr_n,
    output logic rd_fall,
    output logic wr_fall,
    output logic both_high
);

    logic rd_n_q;
    logic rd_n_d;
    logic wr_n_q;
    logic wr_n_d;

    // Next sample of the strobes.
    always_comb begin
        rd_n_d = rd_n;
        wr_n_d = wr_n;
    end

    // Previous-sample registers; they reset low so a strobe still held after reset is not a new edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_n_q <= 1'b0;
            wr_n_q <= 1'b0;
        end else begin
            rd_n_q <= rd_n_d;
            wr_n_q <= wr_n_d;
        end
    end

    assign rd_fall   = rd_n_q & ~rd_n;
    assign wr_fall   = wr_n_q & ~wr_n;
    assign both_high = rd_n & wr_n;

endmodule

// File: rtl/msx_bus_transaction.sv
// Turns qualified MSX bus strobes into peripheral request/response transactions
// and drives the DOUT/BUSDIR_n/WAIT_n return path.
module msx_bus_transaction
    import msx_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] BUS_ADDR,
    input  logic [7:0]  BUS_DIN,
    input  logic        BUS_SLTSL_n,
    input  logic        BUS_MERQ_n,
    input  logic        BUS_IORQ_n,
    input  logic        BUS_M1_n,
    input  logic        BUS_RFSH_n,
    input  logic        BUS_RD_n,
    input  logic        BUS_WR_n,
    output logic [7:0]  BUS_DOUT,
    output logic        BUS_BUSDIR_n,
    output logic        BUS_WAIT_n,
    output logic        REQ_VALID,
    input  logic        REQ_READY,
    output logic        REQ_WRITE,
    output logic        REQ_IO,
    output logic [15:0] REQ_ADDR,
    output logic [7:0]  REQ_WDATA,
    input  logic        RSP_VALID,
    input  logic        RSP_HIT,
    input  logic [7:0]  RSP_RDATA,
    output logic        TIMEOUT_P
);

    localparam int unsigned   CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic              req_valid_q, req_valid_d;
    logic              req_write_q, req_write_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        dout_q, dout_d;
    logic              busdir_n_q, busdir_n_d;
    logic              wait_n_q, wait_n_d;
    logic              timeout_p_q, timeout_p_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              timeout_hit_s;
    logic              rd_fall_s, wr_fall_s, both_high_s;
    logic              mem_ok_s, io_ok_s;

    msx_bus_strobe_edge u_edge (
        .clk       (CLK),
        .rst       (RESET),
        .rd_n      (BUS_RD_n),
        .wr_n      (BUS_WR_n),
        .rd_fall   (rd_fall_s),
        .wr_fall   (wr_fall_s),
        .both_high (both_high_s)
    );

    // Next-state, latch and registered-output logic.
    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        req_valid_d   = req_valid_q;
        req_write_d   = req_write_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        dout_d        = dout_q;
        busdir_n_d    = busdir_n_q;
        wait_n_d      = wait_n_q;
        timeout_p_d   = 1'b0;
        cnt_d         = cnt_q;
        cnt_inc_s     = cnt_q + CNT_ONE;
        timeout_hit_s = (cnt_inc_s >= TIMEOUT_C);
        mem_ok_s      = mem_qualified(BUS_SLTSL_n, BUS_MERQ_n, BUS_RFSH_n);
        io_ok_s       = io_qualified(BUS_IORQ_n, BUS_M1_n);

        case (state_q)
            IDLE: begin
                if (!BUS_RD_n && !BUS_WR_n) begin
                    state_d = DONE;
                end else if (rd_fall_s || wr_fall_s) begin
                    if (mem_ok_s || io_ok_s) begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        wait_n_d    = 1'b0;
                        cnt_d       = '0;
                        req_write_d = wr_fall_s;
                        kind_d      = mem_ok_s ? KIND_MEM : KIND_IO;
                        addr_d      = BUS_ADDR;
                        wdata_d     = BUS_DIN;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            // Host release beats everything; a handshake beats a timeout in the same cycle.
            REQ: begin
                if (both_high_s) begin
                    state_d     = IDLE;
                    req_valid_d = 1'b0;
                    wait_n_d    = 1'b1;
                end else if (REQ_READY) begin
                    req_valid_d = 1'b0;
                    cnt_d       = cnt_inc_s;
                    if (req_write_q) begin
                        state_d  = DONE;
                        wait_n_d = 1'b1;
                    end else begin
                        state_d  = WAIT_RSP;
                    end
                end else if (timeout_hit_s) begin
                    state_d     = DONE;
                    req_valid_d = 1'b0;
                    wait_n_d    = 1'b1;
                    timeout_p_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            WAIT_RSP: begin
                if (both_high_s) begin
                    state_d  = IDLE;
                    wait_n_d = 1'b1;
                end else if (RSP_VALID) begin
                    wait_n_d = 1'b1;
                    if (RSP_HIT) begin
                        state_d    = DRIVE;
                        dout_d     = RSP_RDATA;
                        busdir_n_d = 1'b0;
                    end else begin
                        state_d    = DONE;
                    end
                end else if (timeout_hit_s) begin
                    state_d     = DONE;
                    wait_n_d    = 1'b1;
                    timeout_p_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            DRIVE: begin
                if (BUS_RD_n) begin
                    state_d    = IDLE;
                    busdir_n_d = 1'b1;
                    dout_d     = BUS_DOUT_IDLE;
                end else begin
                    state_d = DRIVE;
                end
            end
            DONE: begin
                wait_n_d   = 1'b1;
                busdir_n_d = 1'b1;
                if (both_high_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_valid_d = 1'b0;
                wait_n_d    = 1'b1;
                busdir_n_d  = 1'b1;
                dout_d      = BUS_DOUT_IDLE;
            end
        endcase
    end

    // State, latches and output registers; reset releases the host cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            kind_q      <= KIND_MEM;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 8'h00;
            dout_q      <= BUS_DOUT_IDLE;
            busdir_n_q  <= 1'b1;
            wait_n_q    <= 1'b1;
            timeout_p_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dout_q      <= dout_d;
            busdir_n_q  <= busdir_n_d;
            wait_n_q    <= wait_n_d;
            timeout_p_q <= timeout_p_d;
            cnt_q       <= cnt_d;
        end
    end

    assign BUS_DOUT     = dout_q;
    assign BUS_BUSDIR_n = busdir_n_q;
    assign BUS_WAIT_n   = wait_n_q;
    assign REQ_VALID    = req_valid_q;
    assign REQ_WRITE    = req_write_q;
    assign REQ_IO       = (kind_q == KIND_IO);
    assign REQ_ADDR     = addr_q;
    assign REQ_WDATA    = wdata_q;
    assign TIMEOUT_P    = timeout_p_q;

endmodule

// File: tb/tb_msx_bus_transaction.sv
// Directed, table-driven bench for msx_bus_transaction (TIMEOUT=16).
module tb_msx_bus_transaction;

    logic        clk;
    logic        reset;
    logic [15:0] bus_addr;
    logic [7:0]  bus_din;
    logic        sltsl_n, merq_n, iorq_n, m1_n, rfsh_n, rd_n, wr_n;
    logic [7:0]  bus_dout;
    logic        busdir_n, wait_n;
    logic        req_valid, req_ready, req_write, req_io;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_hit;
    logic [7:0]  rsp_rdata;
    logic        timeout_p;

    int total;
    int bad;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  din;
        logic        sltsl_n, merq_n, iorq_n, m1_n, rfsh_n, rd_n, wr_n;
        logic        exp_valid, exp_write, exp_io;
    } vec_t;

    vec_t vecs [9];

    msx_bus_transaction #(.TIMEOUT(16)) dut (
        .CLK(clk), .RESET(reset), .BUS_ADDR(bus_addr), .BUS_DIN(bus_din),
        .BUS_SLTSL_n(sltsl_n), .BUS_MERQ_n(merq_n), .BUS_IORQ_n(iorq_n),
        .BUS_M1_n(m1_n), .BUS_RFSH_n(rfsh_n), .BUS_RD_n(rd_n), .BUS_WR_n(wr_n),
        .BUS_DOUT(bus_dout), .BUS_BUSDIR_n(busdir_n), .BUS_WAIT_n(wait_n),
        .REQ_VALID(req_valid), .REQ_READY(req_ready), .REQ_WRITE(req_write),
        .REQ_IO(req_io), .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .RSP_VALID(rsp_valid), .RSP_HIT(rsp_hit), .RSP_RDATA(rsp_rdata),
        .TIMEOUT_P(timeout_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus_addr = 16'h0000; bus_din = 8'h00;
        sltsl_n = 1'b1; merq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rfsh_n = 1'b1;
        rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic release_bus();
        bus_idle();
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_hit = 1'b0;
        step(); step();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"},  {31'd0, req_valid}, 32'd0);
        chk({tag, "_wait"},   {31'd0, wait_n},    32'd1);
        chk({tag, "_busdir"}, {31'd0, busdir_n},  32'd1);
        chk({tag, "_dout"},   {24'd0, bus_dout},  32'h0000_00FF);
        chk({tag, "_tmo"},    {31'd0, timeout_p}, 32'd0);
        chk({tag, "_regs"},   {6'd0, req_write, req_io, req_wdata, req_addr}, 32'd0);
    endtask

    initial begin
        int low;
        int pulses;
        int vcnt;
        logic ok;
        total = 0; bad = 0;

        //            addr      din    sltsl merq  iorq  m1    rfsh  rd    wr    valid write io
        vecs[0] = '{16'h6000, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{16'h4000, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h0099, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{16'h0098, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h0123, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h00FF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h8001, 8'h42, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h6001, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        bus_idle();
        reset = 1'b1; req_ready = 1'b0; rsp_valid = 1'b0; rsp_hit = 1'b0; rsp_rdata = 8'h00;
        step(); step(); step();
        chk_reset_vals("reset");
        reset = 1'b0;
        step(); step();

        // Table: single transaction per vector, held in REQ for two cycles before READY.
        for (int i = 0; i < 9; i++) begin
            bus_addr = vecs[i].addr; bus_din = vecs[i].din;
            sltsl_n = vecs[i].sltsl_n; merq_n = vecs[i].merq_n; iorq_n = vecs[i].iorq_n;
            m1_n = vecs[i].m1_n; rfsh_n = vecs[i].rfsh_n;
            rd_n = vecs[i].rd_n; wr_n = vecs[i].wr_n;
            step();
            chk($sformatf("v%0d_valid", i), {31'd0, req_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d_wait", i), {31'd0, wait_n}, {31'd0, ~vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_write", i), {31'd0, req_write}, {31'd0, vecs[i].exp_write});
                chk($sformatf("v%0d_io", i), {31'd0, req_io}, {31'd0, vecs[i].exp_io});
                chk($sformatf("v%0d_addr", i), {16'd0, req_addr}, {16'd0, vecs[i].addr});
                chk($sformatf("v%0d_wdata", i), {24'd0, req_wdata}, {24'd0, vecs[i].din});
                bus_addr = 16'hFFFF; bus_din = 8'hEE;
                step();
                chk($sformatf("v%0d_hold", i), {15'd0, req_valid, req_addr}, {15'd0, 1'b1, vecs[i].addr});
                req_ready = 1'b1;
                step();
                req_ready = 1'b0;
                chk($sformatf("v%0d_accept", i), {31'd0, req_valid}, 32'd0);
                chk($sformatf("v%0d_wait_acc", i), {31'd0, wait_n}, {31'd0, vecs[i].exp_write});
                if (!vecs[i].exp_write) begin
                    rsp_valid = 1'b1; rsp_hit = 1'b0; rsp_rdata = 8'h12;
                    step();
                    rsp_valid = 1'b0;
                    chk($sformatf("v%0d_miss", i), {30'd0, wait_n, busdir_n}, 32'd3);
                end
            end else begin
                step();
                chk($sformatf("v%0d_noreq", i), {30'd0, req_valid, wait_n}, 32'd1);
            end
            release_bus();
        end

        // Memory write with READY tied high: exactly one REQ_VALID cycle, no drive.
        req_ready = 1'b1;
        bus_addr = 16'h6000; bus_din = 8'h05; sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
        vcnt = 0; ok = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (req_valid) vcnt++;
            if (busdir_n !== 1'b1) ok = 1'b0;
            if (i == 1) chk("w1_fields", {6'd0, req_write, req_io, req_wdata, req_addr},
                            {6'd0, 1'b1, 1'b0, 8'h05, 16'h6000});
        end
        chk("w1_valid_cycles", vcnt, 32'd1);
        chk("w1_no_busdir", {31'd0, ok}, 32'd1);
        release_bus();

        // IO read hit: WAIT_n low 6 clocks, then A5 driven until RD_n rises.
        req_ready = 1'b1;
        bus_addr = 16'h0098; iorq_n = 1'b0; rd_n = 1'b0;
        low = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (!wait_n) low++;
            if (i == 6) begin rsp_valid = 1'b1; rsp_hit = 1'b1; rsp_rdata = 8'hA5; end
            if (i == 7) begin
                rsp_valid = 1'b0;
                chk("r2_drive", {23'd0, busdir_n, bus_dout}, {23'd0, 1'b0, 8'hA5});
            end
        end
        chk("r2_wait_low", low, 32'd6);
        chk("r2_hold", {22'd0, wait_n, busdir_n, bus_dout}, {22'd0, 1'b1, 1'b0, 8'hA5});
        rd_n = 1'b1;
        step();
        chk("r2_release", {23'd0, busdir_n, bus_dout}, {23'd0, 1'b1, 8'hFF});
        release_bus();

        // Memory read miss: bus never driven, WAIT_n released after the response.
        req_ready = 1'b1;
        bus_addr = 16'h8000; sltsl_n = 1'b0; merq_n = 1'b0; rd_n = 1'b0;
        low = 0; ok = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (!wait_n) low++;
            if (busdir_n !== 1'b1 || bus_dout !== 8'hFF) ok = 1'b0;
            if (i == 3) begin rsp_valid = 1'b1; rsp_hit = 1'b0; rsp_rdata = 8'h5A; end
            if (i == 4) rsp_valid = 1'b0;
        end
        chk("r3_wait_low", low, 32'd3);
        chk("r3_no_drive", {31'd0, ok}, 32'd1);
        chk("r3_wait_end", {31'd0, wait_n}, 32'd1);
        release_bus();

        // IO read never accepted: 16-clock timeout, single pulse.
        bus_addr = 16'h0098; iorq_n = 1'b0; rd_n = 1'b0;
        low = 0; pulses = 0;
        for (int i = 1; i <= 22; i++) begin
            step();
            if (!wait_n) low++;
            if (timeout_p) pulses++;
            if (i == 16) chk("t4_valid_held", {31'd0, req_valid}, 32'd1);
            if (i == 17) chk("t4_abort", {29'd0, req_valid, wait_n, timeout_p}, 32'd3);
        end
        chk("t4_wait_low", low, 32'd16);
        chk("t4_pulses", pulses, 32'd1);
        release_bus();

        // Early release in REQ, then a late response must be ignored.
        bus_addr = 16'h0098; iorq_n = 1'b0; rd_n = 1'b0;
        step(); step();
        rd_n = 1'b1;
        step();
        chk("e_release", {30'd0, req_valid, wait_n}, 32'd1);
        rsp_valid = 1'b1; rsp_hit = 1'b1; rsp_rdata = 8'h3C;
        step();
        rsp_valid = 1'b0;
        chk("e_late_rsp", {23'd0, busdir_n, bus_dout}, {23'd0, 1'b1, 8'hFF});
        release_bus();

        // Reset during WAIT_RSP, late response, then a normal transaction.
        req_ready = 1'b1;
        bus_addr = 16'h4321; bus_din = 8'h66; sltsl_n = 1'b0; merq_n = 1'b0; rd_n = 1'b0;
        step(); step();
        chk("r6_in_wait", {30'd0, req_valid, wait_n}, 32'd0);
        reset = 1'b1;
        step();
        chk_reset_vals("r6");
        reset = 1'b0;
        rsp_valid = 1'b1; rsp_hit = 1'b1; rsp_rdata = 8'h5A;
        step();
        rsp_valid = 1'b0;
        chk("r6_late", {22'd0, wait_n, busdir_n, bus_dout}, {22'd0, 1'b1, 1'b1, 8'hFF});
        release_bus();
        req_ready = 1'b1;
        bus_addr = 16'h6002; bus_din = 8'hC3; sltsl_n = 1'b0; merq_n = 1'b0; wr_n = 1'b0;
        step();
        chk("r6_next", {7'd0, req_valid, req_write, req_wdata, req_addr},
            {7'd0, 1'b1, 1'b1, 8'hC3, 16'h6002});
        step();
        chk("r6_next_done", {30'd0, req_valid, wait_n}, 32'd1);
        release_bus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
